key_debounce_ctrl: RTL
======================

KEY_DEBOUNCE_CTRL -- requirements
Module: key_debounce_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_DEFAULT, default 20'd50000, reset value of the debounce-count register (cycles).
REQ-002 SHALL have port clk, input, 1, single clock for all logic.
REQ-003 SHALL have port reset_n, input, 1, reset; one clock, reset synchronous and active-low.
REQ-004 SHALL have port address, input, 2, Avalon-MM word address.
REQ-005 SHALL have port write_n, input, 1, Avalon-MM write strobe, active-low.
REQ-006 SHALL have port writedata, input, 32, Avalon-MM write data.
REQ-007 SHALL have port chipselect, input, 1, qualifies writes.
REQ-008 SHALL have port readdata, output, 32, registered read data.
REQ-009 SHALL have port in_port, input, 4, raw asynchronous keys, active-low (0 = pressed).
REQ-010 SHALL have port irq, output, 1, level interrupt, active-high.

Function
REQ-011 SHALL pass each in_port bit through a 2-flop synchronizer; sync output valid 2 cycles after sampling.
REQ-012 SHALL keep per key a debounced state bit and a 20-bit counter; counter clears whenever sync bit equals debounced bit.
REQ-013 SHALL, while sync bit differs from debounced bit, increment counter each cycle; when counter reaches DBC-1, flip debounced bit and clear counter on the same edge (DBC = debounce-count register; DBC = 0 treated as 1).
REQ-014 SHALL set press-capture bit k the cycle after debounced bit k falls 1->0.
REQ-015 SHALL drive irq, registered, high the cycle after any (capture & mask) bit is 1; low the cycle after all such bits are 0.
REQ-016 SHALL implement register map: addr0 RO debounced state [3:0]; addr1 RW mask [7:0]; addr2 W1C capture [7:0]; addr3 RW debounce count [19:0]; unused bits read 0.
REQ-017 SHALL return readdata one cycle after address is presented (read latency 1, no waitrequest), updating every cycle.
REQ-018 SHALL perform writes when chipselect=1 and write_n=0; writes to addr0 are ignored.
REQ-019 SHALL, when a W1C clear and a new capture event hit the same bit in the same cycle, leave the bit set (event wins).
REQ-020 SHALL, on write to addr3, clear all four debounce counters in that cycle; debounced state bits unchanged.
REQ-021 SHALL saturate nothing: counter never exceeds DBC-1 because of REQ-013.

Reset
REQ-022 SHALL, on clk edge with reset_n=0: debounced state 4'hF, synchronizer flops 1, counters 0, capture 0, mask 0, debounce count DEBOUNCE_DEFAULT, readdata 0, irq 0.
REQ-023 SHALL discard any in-progress debounce when reset asserts mid-count; no capture event generated by reset release while keys are released.

Configuration
REQ-024 SHALL, with KEY_DEBOUNCE_CTRL_RELEASE_EN defined, set release-capture bit k+4 the cycle after debounced bit k rises 0->1, with mask bits [7:4] gating irq.
REQ-025 SHALL, without KEY_DEBOUNCE_CTRL_RELEASE_EN, ignore release edges; capture and mask bits [7:4] read 0 and writes to them have no effect.

Verification
REQ-026 SHALL cover: DBC=4, mask=1, in_port[0] falls at edge k and holds -> debounced[0]=0 at k+6, capture[0]=1 at k+7, irq=1 at k+8.
REQ-027 SHALL cover: DBC=4, in_port[1] low for 3 cycles then high -> no debounced change, capture stays 0, irq stays 0.
REQ-028 SHALL cover: capture[2]=1, write 0x4 to addr2 in same cycle as new press on key 2 -> capture[2] remains 1; later write 0x4 alone -> 0, irq drops next cycle.
REQ-029 SHALL cover: write 0x3 to addr3 mid-count on key 3 -> counter restarts, debounced flips 3 cycles after write; read addr3 -> 0x00000003 one cycle after address.
REQ-030 SHALL cover: reset_n low during key-0 press mid-count -> after reset, readdata 0, addr0 reads 0xF until fresh DEBOUNCE_DEFAULT-cycle stable press; with RELEASE_EN, release sets capture[4].

Source files
------------

// File: rtl/key_debounce_ctrl_if.sv
// Avalon-MM slave bus bundle for key_debounce_ctrl (word address, registered read data).
interface key_debounce_ctrl_if;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic        chipselect;
    logic [31:0] readdata;

    modport master (
        output address,
        output write_n,
        output writedata,
        output chipselect,
        input  readdata
    );

    modport slave (
        input  address,
        input  write_n,
        input  writedata,
        input  chipselect,
        output readdata
    );
endinterface

// File: rtl/key_debounce_ctrl.sv
// Four-key debouncer with press capture, interrupt mask and Avalon-MM register file.
// Define KEY_DEBOUNCE_CTRL_RELEASE_EN to also capture release edges in capture/mask bits [7:4].
module key_debounce_ctrl #(
    parameter logic [19:0] DEBOUNCE_DEFAULT = 20'd50000
) (
    input  logic               clk,
    input  logic               reset_n,
    key_debounce_ctrl_if.slave bus,
    input  logic [3:0]         in_port,
    output logic               irq
);

`ifdef KEY_DEBOUNCE_CTRL_RELEASE_EN
    localparam logic [7:0] CAP_BITS = 8'hFF;
`else
    localparam logic [7:0] CAP_BITS = 8'h0F;
`endif

    logic [3:0]  sync1_q, sync1_d;
    logic [3:0]  sync2_q, sync2_d;
    logic [3:0]  deb_q, deb_d;
    logic [3:0]  deb_dly_q, deb_dly_d;
    logic [19:0] cnt_q [4];
    logic [19:0] cnt_d [4];
    logic [7:0]  cap_q, cap_d;
    logic [7:0]  mask_q, mask_d;
    logic [19:0] dbc_q, dbc_d;
    logic [31:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    logic        wr_en;
    logic [19:0] dbc_term;
    logic [7:0]  cap_evt;
    logic [7:0]  cap_clr;
    logic        unused_wdata;

    assign unused_wdata = ^bus.writedata[31:20];

    always_comb begin
        wr_en     = bus.chipselect & ~bus.write_n;
        // a debounce count of 0 behaves as 1, so the terminal value floors at 0
        dbc_term  = (dbc_q == 20'd0) ? 20'd0 : dbc_q - 20'd1;
        sync1_d   = in_port;
        sync2_d   = sync1_q;
        deb_dly_d = deb_q;
        deb_d     = deb_q;

        for (int k = 0; k < 4; k++) begin
            cnt_d[k] = 20'd0;
            if (wr_en && (bus.address == 2'd3)) begin
                cnt_d[k] = 20'd0;
            end else if (sync2_q[k] != deb_q[k]) begin
                if (cnt_q[k] >= dbc_term) begin
                    deb_d[k] = ~deb_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 20'd1;
                end
            end
        end

`ifdef KEY_DEBOUNCE_CTRL_RELEASE_EN
        cap_evt = {~deb_dly_q & deb_q, deb_dly_q & ~deb_q};
`else
        cap_evt = {4'h0, deb_dly_q & ~deb_q};
`endif
        cap_clr = (wr_en && (bus.address == 2'd2)) ? bus.writedata[7:0] : 8'h00;
        // a capture event in the same cycle as its W1C clear keeps the bit set
        cap_d   = ((cap_q & ~cap_clr) | cap_evt) & CAP_BITS;

        mask_d = mask_q;
        if (wr_en && (bus.address == 2'd1)) begin
            mask_d = bus.writedata[7:0] & CAP_BITS;
        end

        dbc_d = dbc_q;
        if (wr_en && (bus.address == 2'd3)) begin
            dbc_d = bus.writedata[19:0];
        end

        irq_d = |(cap_q & mask_q);

        case (bus.address)
            2'd0:    rdata_d = {28'd0, deb_q};
            2'd1:    rdata_d = {24'd0, mask_q};
            2'd2:    rdata_d = {24'd0, cap_q};
            2'd3:    rdata_d = {12'd0, dbc_q};
            default: rdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q   <= 4'hF;
            sync2_q   <= 4'hF;
            deb_q     <= 4'hF;
            deb_dly_q <= 4'hF;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= 20'd0;
            end
            cap_q     <= 8'h00;
            mask_q    <= 8'h00;
            dbc_q     <= DEBOUNCE_DEFAULT;
            rdata_q   <= 32'd0;
            irq_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_dly_d;
            for (int k = 0; k < 4; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            cap_q     <= cap_d;
            mask_q    <= mask_d;
            dbc_q     <= dbc_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign irq          = irq_q;

endmodule
